// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported 64-bit backing memory between an instruction-fetch
// port and a data port, alternating grants and aborting accesses that time out.
module mem_port_arbiter #(
  parameter int N       = 64,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         if_req,
  input  logic [N-1:0] if_addr,
  output logic [31:0]  if_rdata,
  output logic         if_valid,
  input  logic         dm_req,
  input  logic         dm_we,
  input  logic [N-1:0] dm_addr,
  input  logic [N-1:0] dm_wdata,
  output logic [N-1:0] dm_rdata,
  output logic         dm_valid,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic         mem_ack,
  input  logic [N-1:0] mem_rdata,
  output logic         stall,
  output logic         err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;
  typedef enum logic {GRANT_IF, GRANT_DM} grant_t;

  state_t        state, state_n;
  grant_t        last_grant, last_grant_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          addr2, addr2_n;
  logic          mem_req_n, mem_we_n;
  logic [N-1:0]  mem_addr_n, mem_wdata_n, dm_rdata_n;
  logic [31:0]   if_rdata_n;
  logic          if_valid_n, dm_valid_n, err_n;
  logic          if_elig, dm_elig, grant_if, grant_dm, timed_out;

  // Sub-doubleword address bits are dropped; bit 2 of the fetch address is kept separately.
  logic addr_lsbs_unused;
  assign addr_lsbs_unused = ^{if_addr[1:0], dm_addr[2:0]};

  // A requester whose valid is high has not yet had a chance to drop req.
  assign if_elig   = if_req & ~if_valid;
  assign dm_elig   = dm_req & ~dm_valid;
  assign grant_if  = if_elig & (~dm_elig | (last_grant == GRANT_DM));
  assign grant_dm  = dm_elig & ~grant_if;
  assign timed_out = (cnt == CNT_LAST);

  assign stall = (if_req & ~if_valid) | (dm_req & ~dm_valid);

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    cnt_n        = cnt;
    addr2_n      = addr2;
    mem_req_n    = mem_req;
    mem_we_n     = mem_we;
    mem_addr_n   = mem_addr;
    mem_wdata_n  = mem_wdata;
    if_rdata_n   = if_rdata;
    dm_rdata_n   = dm_rdata;
    if_valid_n   = 1'b0;
    dm_valid_n   = 1'b0;
    err_n        = 1'b0;

    case (state)
      IDLE: begin
        if (grant_if) begin
          state_n      = BUSY_IF;
          last_grant_n = GRANT_IF;
          cnt_n        = '0;
          addr2_n      = if_addr[2];
          mem_req_n    = 1'b1;
          mem_we_n     = 1'b0;
          mem_addr_n   = {if_addr[N-1:3], 3'b000};
          mem_wdata_n  = '0;
        end else if (grant_dm) begin
          state_n      = BUSY_DM;
          last_grant_n = GRANT_DM;
          cnt_n        = '0;
          mem_req_n    = 1'b1;
          mem_we_n     = dm_we;
          mem_addr_n   = {dm_addr[N-1:3], 3'b000};
          mem_wdata_n  = dm_wdata;
        end
      end

      BUSY_IF: begin
        if (mem_ack) begin
          state_n    = IDLE;
          mem_req_n  = 1'b0;
          if_valid_n = 1'b1;
          if_rdata_n = addr2 ? mem_rdata[63:32] : mem_rdata[31:0];
        end else if (timed_out) begin
          state_n    = IDLE;
          mem_req_n  = 1'b0;
          if_valid_n = 1'b1;
          err_n      = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      BUSY_DM: begin
        if (mem_ack) begin
          state_n    = IDLE;
          mem_req_n  = 1'b0;
          dm_valid_n = 1'b1;
          if (!mem_we) dm_rdata_n = mem_rdata;
        end else if (timed_out) begin
          state_n    = IDLE;
          mem_req_n  = 1'b0;
          dm_valid_n = 1'b1;
          err_n      = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      default: begin
        state_n   = IDLE;
        mem_req_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GRANT_DM;
      cnt        <= '0;
      addr2      <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      if_valid   <= 1'b0;
      dm_valid   <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      cnt        <= cnt_n;
      addr2      <= addr2_n;
      mem_req    <= mem_req_n;
      mem_we     <= mem_we_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
      if_rdata   <= if_rdata_n;
      dm_rdata   <= dm_rdata_n;
      if_valid   <= if_valid_n;
      dm_valid   <= dm_valid_n;
      err        <= err_n;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [63:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_req;
  logic        dm_we;
  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic [63:0] dm_rdata;
  logic        dm_valid;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        stall;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.N(64), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .err(err)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    reset = 1'b1; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0;
    dm_addr = '0; dm_wdata = '0; mem_ack = 0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
    checks++; if (if_valid !== 1'b0 || dm_valid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_pulses got if_valid=%b dm_valid=%b err=%b exp 0", if_valid, dm_valid, err); end
    checks++; if (if_rdata !== 32'h0 || dm_rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata got %h/%h exp 0", if_rdata, dm_rdata); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    reset = 1'b0;
  endtask

  task automatic test_single_fetch;
    @(negedge clk); if_req = 1; if_addr = 64'h104;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fetch_stall_req got %b exp 1", stall); end
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL fetch_mem_req got req=%b we=%b exp 1/0", mem_req, mem_we); end
    checks++; if (mem_addr !== 64'h100) begin errors++; $display("FAIL fetch_mem_addr got %h exp 100", mem_addr); end
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || stall !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("FAIL fetch_busy got req=%b stall=%b valid=%b exp 1/1/0", mem_req, stall, if_valid); end
    @(negedge clk); mem_ack = 1; mem_rdata = 64'hAAAA_BBBB_1111_2222;
    @(negedge clk); mem_ack = 0;
    checks++; if (if_valid !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL fetch_done got valid=%b req=%b exp 1/0", if_valid, mem_req); end
    checks++; if (if_rdata !== 32'hAAAA_BBBB) begin errors++; $display("FAIL fetch_rdata got %h exp aaaabbbb", if_rdata); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fetch_stall_done got %b exp 0", stall); end
    if_req = 0;
    @(negedge clk);
    checks++; if (if_valid !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL fetch_single_pulse got valid=%b req=%b exp 0/0", if_valid, mem_req); end
  endtask

  task automatic test_data_write;
    @(negedge clk); dm_req = 1; dm_we = 1; dm_addr = 64'h208; dm_wdata = 64'hDEAD_BEEF_0000_0001;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL write_req got req=%b we=%b exp 1/1", mem_req, mem_we); end
    checks++; if (mem_addr !== 64'h208) begin errors++; $display("FAIL write_addr got %h exp 208", mem_addr); end
    checks++; if (mem_wdata !== 64'hDEAD_BEEF_0000_0001) begin errors++; $display("FAIL write_wdata got %h exp deadbeef00000001", mem_wdata); end
    @(negedge clk); mem_ack = 1; mem_rdata = 64'h5555_5555_5555_5555;
    @(negedge clk); mem_ack = 0;
    checks++; if (dm_valid !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL write_done got valid=%b err=%b exp 1/0", dm_valid, err); end
    checks++; if (dm_rdata !== 64'h0) begin errors++; $display("FAIL write_rdata_hold got %h exp 0", dm_rdata); end
    dm_req = 0; dm_we = 0;
    @(negedge clk);
    checks++; if (dm_valid !== 1'b0) begin errors++; $display("FAIL write_single_pulse got %b exp 0", dm_valid); end
  endtask

  task automatic test_misaligned_read;
    @(negedge clk); dm_req = 1; dm_we = 0; dm_addr = 64'h20F;
    @(negedge clk);
    checks++; if (mem_addr !== 64'h208 || mem_we !== 1'b0) begin errors++; $display("FAIL misaligned_addr got %h we=%b exp 208/0", mem_addr, mem_we); end
    mem_ack = 1; mem_rdata = 64'hCAFE_F00D_1234_5678;
    @(negedge clk); mem_ack = 0;
    checks++; if (dm_valid !== 1'b1 || dm_rdata !== 64'hCAFE_F00D_1234_5678) begin errors++; $display("FAIL misaligned_read got valid=%b data=%h exp 1/cafef00d12345678", dm_valid, dm_rdata); end
    dm_req = 0;
  endtask

  task automatic test_contention;
    int hi_cycles;
    hi_cycles = 0;
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0;
    if_req = 1; if_addr = 64'h500; dm_req = 1; dm_we = 0; dm_addr = 64'h600;
    @(negedge clk);
    if (mem_req) hi_cycles++;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h500) begin errors++; $display("FAIL contention_first_if got req=%b addr=%h exp 1/500", mem_req, mem_addr); end
    mem_ack = 1; mem_rdata = 64'h0102_0304_0506_0708;
    @(negedge clk); mem_ack = 0;
    if (mem_req) hi_cycles++;
    checks++; if (if_valid !== 1'b1 || dm_valid !== 1'b0 || if_rdata !== 32'h0506_0708) begin errors++; $display("FAIL contention_if_done got valid=%b/%b data=%h exp 1/0/05060708", if_valid, dm_valid, if_rdata); end
    if_req = 0;
    @(negedge clk);
    if (mem_req) hi_cycles++;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h600 || mem_we !== 1'b0) begin errors++; $display("FAIL contention_second_dm got req=%b addr=%h we=%b exp 1/600/0", mem_req, mem_addr, mem_we); end
    mem_ack = 1; mem_rdata = 64'h1122_3344_5566_7788;
    @(negedge clk); mem_ack = 0;
    if (mem_req) hi_cycles++;
    checks++; if (dm_valid !== 1'b1 || dm_rdata !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL contention_dm_done got valid=%b data=%h exp 1/1122334455667788", dm_valid, dm_rdata); end
    dm_req = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_req) hi_cycles++;
    end
    checks++; if (hi_cycles !== 2) begin errors++; $display("FAIL contention_req_cycles got %0d exp 2", hi_cycles); end
  endtask

  task automatic test_timeout;
    int busy;
    busy = 0;
    @(negedge clk); dm_req = 1; dm_we = 0; dm_addr = 64'h700;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h700 || stall !== 1'b1) begin errors++; $display("FAIL timeout_grant got req=%b addr=%h stall=%b exp 1/700/1", mem_req, mem_addr, stall); end
    if_req = 1; if_addr = 64'h10;
    while (mem_req === 1'b1 && busy < 40) begin
      busy++;
      @(negedge clk);
    end
    checks++; if (busy !== 16) begin errors++; $display("FAIL timeout_busy_cycles got %0d exp 16", busy); end
    checks++; if (err !== 1'b1 || dm_valid !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("FAIL timeout_pulse got err=%b dm_valid=%b if_valid=%b exp 1/1/0", err, dm_valid, if_valid); end
    checks++; if (dm_rdata !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL timeout_rdata_hold got %h exp 1122334455667788", dm_rdata); end
    dm_req = 0;
    @(negedge clk);
    checks++; if (err !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 64'h10) begin errors++; $display("FAIL timeout_next_if got err=%b req=%b addr=%h exp 0/1/10", err, mem_req, mem_addr); end
    mem_ack = 1; mem_rdata = 64'h0123_4567_89AB_CDEF;
    @(negedge clk); mem_ack = 0;
    checks++; if (if_valid !== 1'b1 || if_rdata !== 32'h89AB_CDEF) begin errors++; $display("FAIL timeout_if_done got valid=%b data=%h exp 1/89abcdef", if_valid, if_rdata); end
    if_req = 0;
  endtask

  task automatic test_reset_mid_access;
    @(negedge clk); if_req = 1; if_addr = 64'h20;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL midreset_busy got %b exp 1", mem_req); end
    reset = 1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL midreset_req_drop got %b exp 0", mem_req); end
    reset = 0; if_req = 0; mem_ack = 1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk); mem_ack = 0;
    checks++; if (if_valid !== 1'b0 || mem_req !== 1'b0 || if_rdata !== 32'h0) begin errors++; $display("FAIL midreset_ack_ignored got valid=%b req=%b data=%h exp 0/0/0", if_valid, mem_req, if_rdata); end
    if_req = 1; if_addr = 64'h28; dm_req = 1; dm_we = 0; dm_addr = 64'h400;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h28) begin errors++; $display("FAIL midreset_tie_if got req=%b addr=%h exp 1/28", mem_req, mem_addr); end
    mem_ack = 1; mem_rdata = 64'h1111_2222_3333_4444;
    @(negedge clk); mem_ack = 0;
    checks++; if (if_valid !== 1'b1 || if_rdata !== 32'h3333_4444) begin errors++; $display("FAIL midreset_if_done got valid=%b data=%h exp 1/33334444", if_valid, if_rdata); end
    if_req = 0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h400) begin errors++; $display("FAIL midreset_dm_grant got req=%b addr=%h exp 1/400", mem_req, mem_addr); end
    mem_ack = 1; mem_rdata = 64'h77;
    @(negedge clk); mem_ack = 0;
    checks++; if (dm_valid !== 1'b1 || dm_rdata !== 64'h77) begin errors++; $display("FAIL midreset_dm_done got valid=%b data=%h exp 1/77", dm_valid, dm_rdata); end
    dm_req = 0;
  endtask

  task automatic test_addr_change;
    @(negedge clk); mem_ack = 1; mem_rdata = 64'hBAD;
    @(negedge clk); mem_ack = 0;
    checks++; if (if_valid !== 1'b0 || dm_valid !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL idle_ack_ignored got %b/%b/%b exp 0/0/0", if_valid, dm_valid, mem_req); end
    if_req = 1; if_addr = 64'h0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h0) begin errors++; $display("FAIL addrchg_grant got req=%b addr=%h exp 1/0", mem_req, mem_addr); end
    if_addr = 64'h40;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h0) begin errors++; $display("FAIL addrchg_hold got req=%b addr=%h exp 1/0", mem_req, mem_addr); end
    mem_ack = 1; mem_rdata = 64'h9999_8888_7777_6666;
    @(negedge clk); mem_ack = 0;
    checks++; if (if_valid !== 1'b1 || if_rdata !== 32'h7777_6666) begin errors++; $display("FAIL addrchg_done got valid=%b data=%h exp 1/77776666", if_valid, if_rdata); end
    if_req = 0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_data_write();
    test_misaligned_read();
    test_contention();
    test_timeout();
    test_reset_mid_access();
    test_addr_change();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
